// File: rtl/bitstream_to_binary.sv
// bitstream_to_binary: counts ones over a window of 2^WINDOW_BITS valid samples of a
// unipolar bitstream and reports the count and its bipolar equivalent 2*count - N.
module bitstream_to_binary #(
    parameter int WINDOW_BITS = 10,
    parameter bit CONTINUOUS  = 0
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          x,
    input  logic                          x_valid,
    output logic                          busy,
    output logic                          done,
    output logic [WINDOW_BITS:0]          value,
    output logic signed [WINDOW_BITS+1:0] value_bipolar
);
    localparam logic [WINDOW_BITS+1:0] W_N = (WINDOW_BITS+2)'(1 << WINDOW_BITS);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 r_state;
    logic [WINDOW_BITS:0]   r_ones;
    logic [WINDOW_BITS-1:0] r_sample;
    logic [WINDOW_BITS:0]   w_sum;

    assign w_sum = r_ones + {{WINDOW_BITS{1'b0}}, x};

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_ones        <= '0;
            r_sample      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            value         <= '0;
            value_bipolar <= $signed(-W_N);
        end else begin
            done <= 1'b0;
            if (clear) begin
                r_state  <= IDLE;
                busy     <= 1'b0;
                r_ones   <= '0;
                r_sample <= '0;
            end else if (r_state == IDLE) begin
                if (start) begin
                    r_state  <= ACCUM;
                    busy     <= 1'b1;
                    r_ones   <= '0;
                    r_sample <= '0;
                end
            end else if (x_valid) begin
                // last sample of the window: publish the sum including this sample
                if (&r_sample) begin
                    value         <= w_sum;
                    value_bipolar <= $signed({w_sum, 1'b0} - W_N);
                    done          <= 1'b1;
                    r_ones        <= '0;
                    r_sample      <= '0;
                    r_state       <= CONTINUOUS ? ACCUM : IDLE;
                    busy          <= CONTINUOUS;
                end else begin
                    r_ones   <= w_sum;
                    r_sample <= r_sample + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bitstream_to_binary.sv
// tb_bitstream_to_binary: directed and randomized windows on a one-shot and a continuous
// instance, checked against a sample-counting reference model.
module tb_bitstream_to_binary;
    logic clk = 1'b0, n_rst = 1'b0, x = 1'b0, x_valid = 1'b0;
    logic start0 = 1'b0, clear0 = 1'b0, start1 = 1'b0, clear1 = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [10:0] value0, value1;
    logic signed [11:0] vb0, vb1;

    int tests = 0, fails = 0, cyc_n = 0, d0_cnt = 0, d1_cnt = 0, b1_low = 0;

    bitstream_to_binary #(.WINDOW_BITS(10), .CONTINUOUS(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start0), .clear(clear0), .x(x), .x_valid(x_valid),
        .busy(busy0), .done(done0), .value(value0), .value_bipolar(vb0));

    bitstream_to_binary #(.WINDOW_BITS(10), .CONTINUOUS(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start(start1), .clear(clear1), .x(x), .x_valid(x_valid),
        .busy(busy1), .done(done1), .value(value1), .value_bipolar(vb1));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        d0_cnt += int'(done0);
        d1_cnt += int'(done1);
        b1_low += int'(!busy1);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit gen(input int mode, input int n);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return n % 2 == 0;
            3: return n % 57 == 0;
            5: return n < 256;
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    // Feeds one window of 1024 valid samples; the model is simply the count of ones fed.
    task automatic run_window(input bit cont, input int mode, input int vmode, input int mid_start,
                              output int t_done, output int cnt);
        int n = 0, c = 0, d0s = d0_cnt, d1s = d1_cnt;
        bit v;
        cnt = 0;
        while (n < 1024 && c < 5000) begin
            v = vmode == 0 ? 1'b1 : vmode == 1 ? (c % 3 != 2) : ($urandom_range(3) != 0);
            x = v ? gen(mode, n) : 1'($urandom_range(1));
            x_valid = v;
            start0 = !cont && v && n == mid_start;
            if (v) begin
                cnt += int'(x);
                n++;
            end
            c++;
            cyc();
        end
        start0 = 1'b0;
        x_valid = 1'b0;
        t_done = cyc_n;
        chk("samples_fed", n, 1024);
        chk("done_pulse", cont ? done1 : done0, 1);
        chk("done_count", cont ? d1_cnt - d1s : d0_cnt - d0s, 1);
        chk("value", cont ? value1 : value0, cnt);
        chk("value_bipolar", cont ? vb1 : vb0, 2 * cnt - 1024);
        chk("busy_after", cont ? busy1 : busy0, int'(cont));
    endtask

    task automatic feed_ones(input int k);
        x = 1'b1;
        x_valid = 1'b1;
        repeat (k) cyc();
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        x = 1'b1;
        x_valid = 1'b1;
        cyc();
        start0 = 1'b0;
    endtask

    initial begin
        int t, t1, t2, t3, cnt, last, d0s, b1s;
        repeat (3) cyc();
        chk("rst_value", value0, 0);
        chk("rst_bipolar", vb0, -1024);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_value_c", value1, 0);
        chk("rst_bipolar_c", vb1, -1024);
        chk("rst_busy_c", busy1, 0);

        n_rst = 1'b1;
        d0s = d0_cnt;
        feed_ones(2000);
        chk("idle_busy", busy0, 0);
        chk("idle_value", value0, 0);
        chk("idle_bipolar", vb0, -1024);
        chk("idle_no_done", d0_cnt - d0s, 0);

        pulse_start0();
        chk("start_busy", busy0, 1);
        run_window(1'b0, 1, 0, -1, t, cnt);
        chk("all_ones", cnt, 1024);
        cyc();
        chk("done_one_cycle", done0, 0);

        pulse_start0();
        run_window(1'b0, 0, 0, -1, t, cnt);
        pulse_start0();
        run_window(1'b0, 2, 1, -1, t, cnt);
        chk("alt_count", cnt, 512);
        pulse_start0();
        run_window(1'b0, 3, 0, 400, t, cnt);
        chk("sparse_count", cnt, 18);
        pulse_start0();
        run_window(1'b0, 4, 2, -1, t, last);

        pulse_start0();
        d0s = d0_cnt;
        feed_ones(500);
        clear0 = 1'b1;
        cyc();
        clear0 = 1'b0;
        chk("clear_busy", busy0, 0);
        chk("clear_keep_value", value0, last);
        chk("clear_keep_bipolar", vb0, 2 * last - 1024);
        feed_ones(1100);
        chk("clear_no_done", d0_cnt - d0s, 0);
        chk("clear_idle_busy", busy0, 0);

        pulse_start0();
        d0s = d0_cnt;
        feed_ones(1023);
        clear0 = 1'b1;
        cyc();
        clear0 = 1'b0;
        chk("clear_beats_done", d0_cnt - d0s, 0);
        chk("clear_last_value", value0, last);
        chk("clear_last_busy", busy0, 0);

        start0 = 1'b1;
        clear0 = 1'b1;
        cyc();
        start0 = 1'b0;
        clear0 = 1'b0;
        chk("clear_over_start", busy0, 0);

        pulse_start0();
        feed_ones(700);
        n_rst = 1'b0;
        cyc();
        chk("midrst_value", value0, 0);
        chk("midrst_bipolar", vb0, -1024);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        n_rst = 1'b1;

        start1 = 1'b1;
        x = 1'b1;
        x_valid = 1'b1;
        cyc();
        start1 = 1'b0;
        b1s = b1_low;
        run_window(1'b1, 1, 0, -1, t1, cnt);
        run_window(1'b1, 0, 0, -1, t2, cnt);
        run_window(1'b1, 5, 0, -1, t3, cnt);
        chk("cont_third", cnt, 256);
        chk("cont_gap1", t2 - t1, 1024);
        chk("cont_gap2", t3 - t2, 1024);
        chk("cont_busy_high", b1_low - b1s, 0);
        clear1 = 1'b1;
        cyc();
        clear1 = 1'b0;
        chk("cont_clear_busy", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
